// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: Set-2 prefix and shift
// scan codes, the byte-handling FSM state type and the scan-to-ASCII table.
package ps2_pkg;

    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_PROC
    } state_t;

    // Extended codes never map; shift turns letters upper-case and the
    // digit row into the US shifted symbols.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                                 input logic       ext,
                                                 input logic       shift);
        logic [7:0] ch;
        ch = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";
                8'h23: ch = "d";  8'h24: ch = "e";  8'h2B: ch = "f";
                8'h34: ch = "g";  8'h33: ch = "h";  8'h43: ch = "i";
                8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
                8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";
                8'h4D: ch = "p";  8'h15: ch = "q";  8'h2D: ch = "r";
                8'h1B: ch = "s";  8'h2C: ch = "t";  8'h3C: ch = "u";
                8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
                8'h35: ch = "y";  8'h1A: ch = "z";
                8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";
                8'h26: ch = "3";  8'h25: ch = "4";  8'h2E: ch = "5";
                8'h36: ch = "6";  8'h3D: ch = "7";  8'h3E: ch = "8";
                8'h46: ch = "9";
                8'h29: ch = 8'h20;
                8'h5A: ch = 8'h0D;
                default: ch = 8'h00;
            endcase
            if (shift) begin
                if (ch >= "a" && ch <= "z") begin
                    ch = ch - 8'h20;
                end else begin
                    case (ch)
                        "0": ch = ")";  "1": ch = "!";  "2": ch = "@";
                        "3": ch = "#";  "4": ch = "$";  "5": ch = "%";
                        "6": ch = "^";  "7": ch = "&";  "8": ch = "*";
                        "9": ch = "(";
                        default: ch = ch;
                    endcase
                end
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Scan-code FIFO handshake between ps2_keyboard (master) and the decoder.
interface ps2_key_decoder_if;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;

    modport master (output kbd_data, kbd_ready, kbd_overflow, input kbd_nextdata_n);
    modport slave  (input kbd_data, kbd_ready, kbd_overflow, output kbd_nextdata_n);
endinterface

// File: rtl/ps2_key_decoder_seg7_hex.sv
// One hex digit to a 7-segment pattern {dp,g,f,e,d,c,b,a}; dp always off.
module seg7_hex #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] seg
);
    logic [7:0] pattern;

    // Active-high pattern first, then polarity applied to the whole byte.
    always_comb begin
        pattern = '0;
        if (!blank) begin
            case (nibble)
                4'h0: pattern = 8'h3F;  4'h1: pattern = 8'h06;
                4'h2: pattern = 8'h5B;  4'h3: pattern = 8'h4F;
                4'h4: pattern = 8'h66;  4'h5: pattern = 8'h6D;
                4'h6: pattern = 8'h7D;  4'h7: pattern = 8'h07;
                4'h8: pattern = 8'h7F;  4'h9: pattern = 8'h6F;
                4'hA: pattern = 8'h77;  4'hB: pattern = 8'h7C;
                4'hC: pattern = 8'h39;  4'hD: pattern = 8'h5E;
                4'hE: pattern = 8'h79;  4'hF: pattern = 8'h71;
                default: pattern = '0;
            endcase
        end
        seg = SEG_ACTIVE_LOW ? ~pattern : pattern;
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// Drains the ps2_keyboard FIFO, decodes Set-2 make/break/E0 sequences,
// tracks the held key and drives six hex digits.
// Optional build macro: PS2_DECODER_SHIFT_EN (shift-aware ASCII).
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned COUNT_W        = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    ps2_key_decoder_if.slave   kbd,
    output logic               key_valid,
    output logic               key_ext,
    output logic [7:0]         key_code,
    output logic [7:0]         key_ascii,
    output logic [COUNT_W-1:0] press_count,
    output logic               ovf_err,
    output logic [7:0]         seg0,
    output logic [7:0]         seg1,
    output logic [7:0]         seg2,
    output logic [7:0]         seg3,
    output logic [7:0]         seg4,
    output logic [7:0]         seg5
);
    state_t     state, state_nx;
    logic [7:0] byte_r;
    logic       brk, ext;
    logic       same_key;
    logic       shift_held, is_shift;
    logic       key_blank;
    logic [7:0] count_lo;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state; pop strobe is a pure decode of ACK so reset lifts it at once.
    always_comb begin
        state_nx            = state;
        kbd.kbd_nextdata_n  = 1'b1;
        case (state)
            ST_IDLE: if (kbd.kbd_ready) state_nx = ST_ACK;
            ST_ACK: begin
                kbd.kbd_nextdata_n = 1'b0;
                state_nx           = ST_PROC;
            end
            ST_PROC: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Capture the FIFO head when leaving IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                              byte_r <= '0;
        else if (state == ST_IDLE && kbd.kbd_ready) byte_r <= kbd.kbd_data;
    end

    // Same code and same prefix as the held key.
    always_comb begin
        same_key = key_valid && (byte_r == key_code) && (ext == key_ext);
    end

`ifdef PS2_DECODER_SHIFT_EN
    always_comb begin
        is_shift = (byte_r == PS2_LSHIFT) || (byte_r == PS2_RSHIFT);
    end

    // Either shift key sets/clears one shared held flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                              shift_held <= 1'b0;
        else if (state == ST_PROC && is_shift)  shift_held <= !brk;
    end
`else
    assign is_shift   = 1'b0;
    assign shift_held = 1'b0;
`endif

    // Byte decode in PROC: prefixes accumulate, anything else consumes them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brk         <= 1'b0;
            ext         <= 1'b0;
            key_valid   <= 1'b0;
            key_ext     <= 1'b0;
            key_code    <= '0;
            key_ascii   <= '0;
            press_count <= '0;
        end else if (state == ST_PROC) begin
            if (byte_r == PS2_EXT) begin
                ext <= 1'b1;
            end else if (byte_r == PS2_BRK) begin
                brk <= 1'b1;
            end else if (is_shift) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (brk) begin
                if (same_key) key_valid <= 1'b0;
                brk <= 1'b0;
                ext <= 1'b0;
            end else begin
                if (!same_key) begin
                    key_code    <= byte_r;
                    key_ext     <= ext;
                    key_valid   <= 1'b1;
                    key_ascii   <= scan_to_ascii(byte_r, ext, shift_held);
                    press_count <= press_count + COUNT_W'(1);
                end
                ext <= 1'b0;
            end
        end
    end

    // Sticky overflow, sampled every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 ovf_err <= 1'b0;
        else if (kbd.kbd_overflow) ovf_err <= 1'b1;
    end

    // Display inputs derived from registered values.
    always_comb begin
        key_blank = !key_valid;
        count_lo  = 8'(press_count);
    end

    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg0 (.nibble(key_code[3:0]),  .blank(key_blank), .seg(seg0));
    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg1 (.nibble(key_code[7:4]),  .blank(key_blank), .seg(seg1));
    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg2 (.nibble(key_ascii[3:0]), .blank(key_blank), .seg(seg2));
    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg3 (.nibble(key_ascii[7:4]), .blank(key_blank), .seg(seg3));
    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg4 (.nibble(count_lo[3:0]),  .blank(1'b0),      .seg(seg4));
    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg5 (.nibble(count_lo[7:4]),  .blank(1'b0),      .seg(seg5));

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a queue stands in for the ps2_keyboard FIFO,
// and a table-driven reference model tracks the expected key state.
module tb_ps2_key_decoder;

    localparam int unsigned CW  = 8;
    localparam bit          SAL = 1'b1;
`ifdef PS2_DECODER_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          key_valid, key_ext, ovf_err;
    logic [7:0]    key_code, key_ascii;
    logic [CW-1:0] press_count;
    logic [7:0]    seg0, seg1, seg2, seg3, seg4, seg5;

    ps2_key_decoder_if kbd();

    ps2_key_decoder #(.COUNT_W(CW), .SEG_ACTIVE_LOW(SAL)) dut (
        .clock(clock), .reset(reset), .kbd(kbd),
        .key_valid(key_valid), .key_ext(key_ext), .key_code(key_code),
        .key_ascii(key_ascii), .press_count(press_count), .ovf_err(ovf_err),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5)
    );

    always #5 clock = ~clock;

    // FIFO stand-in: pop on a sampled low strobe, present head registered.
    logic [7:0] fifo_q[$];
    int         pulses = 0;
    int         wide   = 0;
    logic       prev_low = 1'b0;
    always @(posedge clock) begin
        if (kbd.kbd_nextdata_n === 1'b0) begin
            pulses <= pulses + 1;
            if (prev_low) wide <= wide + 1;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        prev_low      <= (kbd.kbd_nextdata_n === 1'b0);
        kbd.kbd_ready <= (fifo_q.size() != 0);
        kbd.kbd_data  <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // Reference tables.
    logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                     8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                     8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] digit_shift [10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28};
    logic [6:0] hex7 [16] = '{7'h3F,7'h06,7'h5B,7'h4F,7'h66,7'h6D,7'h7D,7'h07,
                              7'h7F,7'h6F,7'h77,7'h7C,7'h39,7'h5E,7'h79,7'h71};

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic e, input logic s);
        if (e) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) return (s ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) return s ? digit_shift[i] : 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_seg(input logic [3:0] n, input logic blank);
        logic [7:0] p;
        p = blank ? 8'h00 : {1'b0, hex7[n]};
        return SAL ? ~p : p;
    endfunction

    // Reference model state.
    logic       m_valid, m_kext, m_brk, m_ext, m_shift, m_ovf;
    logic [7:0] m_code, m_ascii, m_count;
    int         pushed = 0;

    task automatic model_reset();
        m_valid = 0; m_kext = 0; m_brk = 0; m_ext = 0; m_shift = 0;
        m_ovf = 0; m_code = 0; m_ascii = 0; m_count = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic same;
        same = m_valid && (b == m_code) && (m_ext == m_kext);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (SHIFT_EN && (b == 8'h12 || b == 8'h59)) begin
            m_shift = !m_brk; m_brk = 0; m_ext = 0;
        end else if (m_brk) begin
            if (same) m_valid = 0;
            m_brk = 0; m_ext = 0;
        end else begin
            if (!same) begin
                m_code = b; m_kext = m_ext; m_valid = 1;
                m_ascii = ref_ascii(b, m_ext, m_shift);
                m_count = m_count + 8'd1;
            end
            m_ext = 0;
        end
    endtask

    int checks = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, key_valid,   m_valid);
        chk({tag, ".ext"},   key_ext,     m_kext);
        chk({tag, ".code"},  key_code,    m_code);
        chk({tag, ".ascii"}, key_ascii,   m_ascii);
        chk({tag, ".count"}, press_count, m_count);
        chk({tag, ".ovf"},   ovf_err,     m_ovf);
        chk({tag, ".seg0"},  seg0, ref_seg(m_code[3:0],  !m_valid));
        chk({tag, ".seg1"},  seg1, ref_seg(m_code[7:4],  !m_valid));
        chk({tag, ".seg2"},  seg2, ref_seg(m_ascii[3:0], !m_valid));
        chk({tag, ".seg3"},  seg3, ref_seg(m_ascii[7:4], !m_valid));
        chk({tag, ".seg4"},  seg4, ref_seg(m_count[3:0], 1'b0));
        chk({tag, ".seg5"},  seg5, ref_seg(m_count[7:4], 1'b0));
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        fifo_q.push_back(b);
        pushed++;
        model_byte(b);
        repeat (8) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] blank_pat;
        logic [7:0] b;
        int         p0, w0, found, r;
        blank_pat = SAL ? 8'hFF : 8'h00;

        reset = 1'b1;
        kbd.kbd_overflow = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset.nextdata_n", kbd.kbd_nextdata_n, 1'b1);
        check_outputs("reset");
        chk("reset.seg4_zero", seg4, ref_seg(4'h0, 1'b0));
        reset = 1'b0;

        // Make then release of 'a'.
        send(8'h1C);
        check_outputs("t1_make");
        chk("t1_ascii_a", key_ascii, 8'h61);
        send(8'hF0); send(8'h1C);
        check_outputs("t1_break");
        chk("t1_seg0_blank", seg0, blank_pat);
        chk("t1_seg3_blank", seg3, blank_pat);

        // Typematic repeats are not counted; one strobe per byte.
        pulse_reset();
        p0 = pulses; w0 = wide;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        check_outputs("t2_typematic");
        chk("t2_count_one", press_count, 1);
        chk("t2_pulses", pulses - p0, 5);
        chk("t2_pulse_width", wide - w0, 0);

        // Extended key make and release.
        pulse_reset();
        send(8'hE0); send(8'h75);
        check_outputs("t3_ext_make");
        chk("t3_ext_flag", key_ext, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check_outputs("t3_ext_break");

        // Replacement and stale release.
        pulse_reset();
        send(8'h16); send(8'h1E); send(8'hF0); send(8'h16);
        check_outputs("t4_stale");
        chk("t4_count_two", press_count, 2);

        // Sticky overflow; decoding continues.
        @(negedge clock); kbd.kbd_overflow = 1'b1;
        @(negedge clock); kbd.kbd_overflow = 1'b0; m_ovf = 1;
        repeat (3) @(negedge clock);
        chk("t5_ovf_set", ovf_err, 1'b1);
        send(8'h29);
        check_outputs("t5_space");
        chk("t5_ascii_space", key_ascii, 8'h20);

        // Pending break prefix discarded by reset.
        pulse_reset();
        send(8'hF0);
        pulse_reset();
        send(8'h1C);
        check_outputs("t6_after_reset");
        chk("t6_count_one", press_count, 1);

        // Reset during the pop strobe releases it immediately; byte stays queued.
        @(negedge clock);
        fifo_q.push_back(8'h2D);
        pushed++;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clock);
            if (kbd.kbd_nextdata_n === 1'b0) found = 1;
        end
        chk("t7_ack_seen", found, 1);
        reset = 1'b1;
        #1;
        chk("t7_nextdata_released", kbd.kbd_nextdata_n, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        model_byte(8'h2D);
        repeat (10) @(negedge clock);
        check_outputs("t7_requeued");

`ifdef PS2_DECODER_SHIFT_EN
        pulse_reset();
        send(8'h12); send(8'h1C);
        check_outputs("t8_shift");
        chk("t8_upper_a", key_ascii, 8'h41);
        chk("t8_count", press_count, 1);
        send(8'hF0); send(8'h12);
`endif

        // Randomized stream, with occasional back-to-back bursts.
        pulse_reset();
        for (int it = 0; it < 150; it++) begin
            if (it == 77) begin
                @(negedge clock); kbd.kbd_overflow = 1'b1;
                @(negedge clock); kbd.kbd_overflow = 1'b0; m_ovf = 1;
            end
            if (it % 10 == 9) begin
                @(negedge clock);
                for (int k = 0; k < 3; k++) begin
                    b = letter_codes[$urandom_range(0, 25)];
                    if (k == 1) b = 8'hF0;
                    fifo_q.push_back(b);
                    pushed++;
                    model_byte(b);
                end
                repeat (16) @(negedge clock);
                check_outputs("rnd_burst");
            end else begin
                r = $urandom_range(0, 99);
                if (r < 10)      b = 8'hE0;
                else if (r < 25) b = 8'hF0;
                else if (r < 45) b = m_code;
                else if (r < 60) b = (r < 52) ? letter_codes[$urandom_range(0, 25)]
                                              : digit_codes[$urandom_range(0, 9)];
                else if (r < 70) b = (r < 65) ? 8'h12 : 8'h59;
                else if (r < 80) b = (r < 75) ? 8'h29 : 8'h5A;
                else             b = 8'($urandom_range(0, 255));
                send(b);
                check_outputs("rnd");
            end
        end

        chk("end_pulses_eq_bytes", pulses, pushed);
        chk("end_no_wide_pulse", wide, 0);
        chk("end_fifo_drained", fifo_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
